ps2_scancode_rx: RTL and testbench
==================================

// Module: ps2_scancode_rx
// PURPOSE
//  Receives PS/2 keyboard frames and turns them into the scan/scan_received stream
//  consumed by the SAM keyboard matrix stage.
//  - Samples raw ps2clk/ps2data, synchronises and deglitches them, then deserialises
//    11-bit frames (start, 8 data LSB-first, odd parity, stop).
//  - Emits each valid byte with a strobe safe to use as an edge by downstream logic.
//  - Flags parity, framing and timeout errors.
// PARAMETERS
//  FILTER_LEN      8      consecutive equal samples needed before filtered ps2clk changes
//  TIMEOUT_CYCLES  24000  clk cycles allowed between bit strobes inside a frame (~1 ms)
//  TO_W            15     width of timeout counter; 2**TO_W must exceed TIMEOUT_CYCLES
// PORTS
//  clk            in   1  system clock
//  rst            in   1  synchronous, active-high reset
//  ps2clk         in   1  raw PS/2 clock pin, asynchronous
//  ps2data        in   1  raw PS/2 data pin, asynchronous
//  scan           out  8  last valid received byte
//  scan_received  out  1  2-cycle high pulse per valid byte
//  rx_error       out  1  1-cycle pulse on parity, framing or timeout error
//  busy           out  1  high while a frame is in progress (state != IDLE)
// BEHAVIOUR
//  Reset values
//   - scan=8'h00, scan_received=0, rx_error=0, busy=0, state=IDLE.
//   - Synchroniser and filter outputs are forced to 1 (line idle).
//   - Timeout counter and filter counter are 0.
//  Input conditioning
//   - 2-FF synchroniser on each pin.
//   - ps2clk filter: the output flips only after FILTER_LEN consecutive synced samples
//     differ from the current output. Shorter glitches are ignored.
//   - strobe = 1-cycle pulse on the 1->0 transition of the filtered clock.
//   - Data is sampled from synced ps2data in the strobe cycle.
//  FSM (advances only on strobe, except timeout)
//   - IDLE:   data=0 -> DATA, bitcnt=0. data=1 -> stay in IDLE, no error.
//   - DATA:   shreg <= {data, shreg[7:1]}, bitcnt++. After the 8th bit -> PARITY.
//   - PARITY: par_ok <= (^shreg ^ data)==1 (odd parity) -> STOP.
//   - STOP:   data=1 and par_ok -> load scan<=shreg, go to IDLE.
//             Otherwise rx_error pulse, scan unchanged, go to IDLE.
//  Output timing
//   - scan is updated in cycle N, the cycle after the STOP strobe.
//   - scan_received is high in cycles N+1 and N+2, so scan is stable before its rising edge.
//   - scan holds its value until the next valid byte.
//  Timeout
//   - tcnt is cleared on every strobe and in IDLE, and increments otherwise.
//   - If tcnt reaches TIMEOUT_CYCLES-1 in a non-IDLE state:
//     go to IDLE, rx_error pulse, partial byte discarded.
//  Boundary cases
//   - Strobe in the same cycle as timeout: the timeout wins. The strobe is dropped, not
//     reinterpreted as a start bit.
//   - A new frame may start while scan_received is still high. The pulse completes
//     unaffected, and the next byte's pulse cannot overlap because of the PS/2 bit rate.
//   - rst mid-frame: abandon the frame and apply all reset values; no pulse, no error.
//   - rx_error and scan_received are never high in the same cycle.
//   - No transmit (host->device) support: both pins are input-only.
// TESTING
//  (PS/2 bit period 80 us; ps2clk low 40 us / high 40 us)
//  1. Frame 0x1C: bits 0,0,0,1,1,1,0,0,0, parity 0, stop 1
//     -> scan=8'h1C, scan_received high exactly 2 clk, rx_error=0, busy falls after stop.
//  2. Frames 0xF0 (parity 1) then 0x1C back-to-back
//     -> two pulses; scan=8'hF0 at the first rising edge, 8'h1C at the second.
//  3. Frame 0x1C with parity bit 1
//     -> no scan_received, rx_error 1 clk, scan keeps its previous value.
//     Same frame with stop bit 0 -> identical response.
//  4. ps2clk low glitch of FILTER_LEN-1 cycles while idle -> no strobe, busy=0, no outputs.
//     Glitch of FILTER_LEN cycles with data=0 -> busy=1.
//  5. Start bit plus 4 data bits, then silence > TIMEOUT_CYCLES
//     -> rx_error pulse, busy=0; following frame 0x5A (parity 1) received correctly.
//  6. rst pulsed after 5 data bits
//     -> all outputs at reset values; following frame 0x12 (parity 1) gives scan=8'h12.

Source files
------------

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: synchronises and deglitches the raw pins, deserialises
// 11-bit frames and emits each valid byte with a 2-cycle scan_received pulse.
module ps2_scancode_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 24000,
    parameter int TO_W           = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2clk,
    input  logic       ps2data,
    output logic [7:0] scan,
    output logic       scan_received,
    output logic       rx_error,
    output logic       busy
);

    localparam int FC_W = $clog2(FILTER_LEN + 1);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FILTER_LEN - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    // Odd parity: data bits plus parity bit must contain an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] b, input logic p);
        return ^{b, p};
    endfunction

    logic [1:0]      clk_sync;
    logic [1:0]      dat_sync;
    logic            filt_clk;
    logic            filt_clk_d;
    logic [FC_W-1:0] fcnt;
    logic            strobe;
    logic            data_bit;

    state_t          state;
    logic [2:0]      bitcnt;
    logic [7:0]      shreg;
    logic            par_ok;
    logic [TO_W-1:0] tcnt;
    logic            vld_p0;
    logic            vld_p1;

    // Stage: pin synchronisers, idle level is high
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[0], ps2clk};
            dat_sync <= {dat_sync[0], ps2data};
        end
    end

    // Stage: clock deglitch filter and falling-edge detect
    always_ff @(posedge clk) begin
        if (rst) begin
            filt_clk   <= 1'b1;
            filt_clk_d <= 1'b1;
            fcnt       <= '0;
        end else begin
            filt_clk_d <= filt_clk;
            if (clk_sync[1] != filt_clk) begin
                if (fcnt == FC_LAST) begin
                    filt_clk <= ~filt_clk;
                    fcnt     <= '0;
                end else begin
                    fcnt <= fcnt + FC_W'(1);
                end
            end else begin
                fcnt <= '0;
            end
        end
    end

    assign strobe   = filt_clk_d & ~filt_clk;
    assign data_bit = dat_sync[1];

    // Stage: frame FSM; timeout takes priority over a coincident strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            scan     <= 8'h00;
            rx_error <= 1'b0;
            vld_p0   <= 1'b0;
            tcnt     <= '0;
        end else begin
            rx_error <= 1'b0;
            vld_p0   <= 1'b0;
            if (state == IDLE || strobe) begin
                tcnt <= '0;
            end else begin
                tcnt <= tcnt + TO_W'(1);
            end
            if (state != IDLE && tcnt == TO_LAST) begin
                state    <= IDLE;
                busy     <= 1'b0;
                rx_error <= 1'b1;
            end else if (strobe) begin
                case (state)
                    IDLE: begin
                        if (!data_bit) begin
                            state  <= DATA;
                            busy   <= 1'b1;
                            bitcnt <= 3'd0;
                        end
                    end
                    DATA: begin
                        shreg  <= {data_bit, shreg[7:1]};
                        bitcnt <= bitcnt + 3'd1;
                        if (bitcnt == 3'd7) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
                        par_ok <= odd_parity_ok(shreg, data_bit);
                        state  <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (data_bit && par_ok) begin
                            scan   <= shreg;
                            vld_p0 <= 1'b1;
                        end else begin
                            rx_error <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Stage: stretch the load marker into a pulse one cycle behind scan
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1        <= 1'b0;
            scan_received <= 1'b0;
        end else begin
            vld_p1        <= vld_p0;
            scan_received <= vld_p0 | vld_p1;
        end
    end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Bench for ps2_scancode_rx: directed PS/2 frames plus randomized frames with
// injected parity/stop faults, compared against a frame-level model.
module tb_ps2_scancode_rx;

    localparam int FILTER_LEN = 8;
    localparam int TIMEOUT    = 400;
    localparam int TO_W       = 10;
    localparam int HALF       = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2clk;
    logic       ps2data;
    logic [7:0] scan;
    logic       scan_received;
    logic       rx_error;
    logic       busy;

    int checks = 0;
    int errors = 0;

    ps2_scancode_rx #(
        .FILTER_LEN(FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT),
        .TO_W(TO_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ps2clk(ps2clk),
        .ps2data(ps2data),
        .scan(scan),
        .scan_received(scan_received),
        .rx_error(rx_error),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Output monitor
    logic [7:0] rcv_q[$];
    int         width_q[$];
    int         run = 0;
    int         err_cnt = 0;
    int         err_wide = 0;
    int         overlap = 0;
    int         unstable = 0;
    logic       sr_prev = 1'b0;
    logic       err_prev = 1'b0;
    logic [7:0] scan_prev = 8'h00;

    always @(negedge clk) begin
        if (scan_received && !sr_prev) begin
            rcv_q.push_back(scan);
            if (scan !== scan_prev) unstable <= unstable + 1;
        end
        if (scan_received) run <= run + 1;
        else if (run != 0) begin
            width_q.push_back(run);
            run <= 0;
        end
        if (rx_error) err_cnt <= err_cnt + 1;
        if (rx_error && err_prev) err_wide <= err_wide + 1;
        if (rx_error && scan_received) overlap <= overlap + 1;
        sr_prev   <= scan_received;
        err_prev  <= rx_error;
        scan_prev <= scan;
    end

    logic [7:0] exp_scan = 8'h00;

    function automatic logic [10:0] make_frame(input logic [7:0] d, input logic par_flip,
                                               input logic stop);
        logic par;
        par = ~(^d) ^ par_flip;
        return {stop, par, d, 1'b0};
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [10:0] f, input int first, input int last,
                             input int half);
        for (int i = first; i <= last; i++) begin
            ps2data = f[i];
            wait_cycles(half);
            ps2clk = 1'b0;
            wait_cycles(half);
            ps2clk = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [10:0] f, input int half);
        send_bits(f, 0, 10, half);
        ps2data = 1'b1;
        wait_cycles(30);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        ps2clk = 1'b1;
        ps2data = 1'b1;
        wait_cycles(5);
        checks++;
        if (scan !== 8'h00 || scan_received !== 1'b0 || rx_error !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: scan=%h sr=%b err=%b busy=%b, want 00 0 0 0",
                     scan, scan_received, rx_error, busy);
        end
        rst = 1'b0;
        wait_cycles(20);
        checks++;
        if (scan !== 8'h00 || scan_received !== 1'b0 || rx_error !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: scan=%h sr=%b err=%b busy=%b, want 00 0 0 0",
                     scan, scan_received, rx_error, busy);
        end
    endtask

    task automatic test_single_frame;
        int n0, e0, w0;
        logic [10:0] f;
        n0 = rcv_q.size(); e0 = err_cnt; w0 = width_q.size();
        f = make_frame(8'h1C, 1'b0, 1'b1);
        send_bits(f, 0, 0, HALF);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_in_frame: got %b want 1", busy);
        end
        send_bits(f, 1, 10, HALF);
        ps2data = 1'b1;
        wait_cycles(30);
        checks++;
        if (rcv_q.size() != n0 + 1 || rcv_q[rcv_q.size()-1] !== 8'h1C) begin
            errors++;
            $display("FAIL single_scan: pulses=%0d last=%h want 1 pulse of 1c",
                     rcv_q.size() - n0, rcv_q[rcv_q.size()-1]);
        end
        checks++;
        if (width_q.size() != w0 + 1 || width_q[width_q.size()-1] != 2) begin
            errors++;
            $display("FAIL single_width: width=%0d want 2", width_q[width_q.size()-1]);
        end
        checks++;
        if (err_cnt != e0 || busy !== 1'b0 || scan !== 8'h1C) begin
            errors++;
            $display("FAIL single_state: new_err=%0d busy=%b scan=%h want 0 0 1c",
                     err_cnt - e0, busy, scan);
        end
        exp_scan = 8'h1C;
    endtask

    task automatic test_back_to_back;
        int n0;
        n0 = rcv_q.size();
        send_bits(make_frame(8'hF0, 1'b0, 1'b1), 0, 10, HALF);
        ps2data = 1'b1;
        wait_cycles(2);
        send_frame(make_frame(8'h1C, 1'b0, 1'b1), HALF);
        checks++;
        if (rcv_q.size() != n0 + 2) begin
            errors++;
            $display("FAIL b2b_count: pulses=%0d want 2", rcv_q.size() - n0);
        end else begin
            checks++;
            if (rcv_q[n0] !== 8'hF0 || rcv_q[n0+1] !== 8'h1C) begin
                errors++;
                $display("FAIL b2b_values: got %h %h want f0 1c", rcv_q[n0], rcv_q[n0+1]);
            end
        end
        exp_scan = 8'h1C;
    endtask

    task automatic test_errors;
        int n0, e0;
        for (int k = 0; k < 2; k++) begin
            n0 = rcv_q.size(); e0 = err_cnt;
            if (k == 0) send_frame(make_frame(8'h1C, 1'b1, 1'b1), HALF);
            else        send_frame(make_frame(8'h1C, 1'b0, 1'b0), HALF);
            checks++;
            if (rcv_q.size() != n0 || err_cnt != e0 + 1 || scan !== exp_scan || busy !== 1'b0) begin
                errors++;
                $display("FAIL bad_frame_%0d: pulses=%0d errs=%0d scan=%h busy=%b want 0 1 %h 0",
                         k, rcv_q.size() - n0, err_cnt - e0, scan, busy, exp_scan);
            end
        end
    endtask

    task automatic test_glitch;
        int n0, e0;
        n0 = rcv_q.size(); e0 = err_cnt;
        ps2data = 1'b0;
        wait_cycles(5);
        ps2clk = 1'b0;
        wait_cycles(FILTER_LEN - 1);
        ps2clk = 1'b1;
        wait_cycles(20);
        checks++;
        if (busy !== 1'b0 || rcv_q.size() != n0 || err_cnt != e0) begin
            errors++;
            $display("FAIL short_glitch: busy=%b pulses=%0d errs=%0d want 0 0 0",
                     busy, rcv_q.size() - n0, err_cnt - e0);
        end
        ps2clk = 1'b0;
        wait_cycles(FILTER_LEN);
        ps2clk = 1'b1;
        wait_cycles(20);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL long_glitch: busy=%b want 1", busy);
        end
        ps2data = 1'b1;
        wait_cycles(TIMEOUT + 50);
        checks++;
        if (busy !== 1'b0 || err_cnt != e0 + 1) begin
            errors++;
            $display("FAIL glitch_timeout: busy=%b errs=%0d want 0 1", busy, err_cnt - e0);
        end
    endtask

    task automatic test_timeout;
        int n0, e0;
        n0 = rcv_q.size(); e0 = err_cnt;
        send_bits(make_frame(8'h5A, 1'b0, 1'b1), 0, 4, HALF);
        ps2data = 1'b1;
        checks++;
        if (busy !== 1'b1 || err_cnt != e0) begin
            errors++;
            $display("FAIL partial_busy: busy=%b errs=%0d want 1 0", busy, err_cnt - e0);
        end
        wait_cycles(TIMEOUT + 50);
        checks++;
        if (busy !== 1'b0 || err_cnt != e0 + 1 || rcv_q.size() != n0) begin
            errors++;
            $display("FAIL timeout: busy=%b errs=%0d pulses=%0d want 0 1 0",
                     busy, err_cnt - e0, rcv_q.size() - n0);
        end
        send_frame(make_frame(8'h5A, 1'b0, 1'b1), HALF);
        checks++;
        if (rcv_q.size() != n0 + 1 || scan !== 8'h5A) begin
            errors++;
            $display("FAIL after_timeout: pulses=%0d scan=%h want 1 5a", rcv_q.size() - n0, scan);
        end
        exp_scan = 8'h5A;
    endtask

    task automatic test_reset_mid_frame;
        int n0, e0;
        n0 = rcv_q.size(); e0 = err_cnt;
        send_bits(make_frame(8'h12, 1'b0, 1'b1), 0, 5, HALF);
        ps2data = 1'b1;
        rst = 1'b1;
        wait_cycles(3);
        rst = 1'b0;
        wait_cycles(2);
        checks++;
        if (scan !== 8'h00 || scan_received !== 1'b0 || rx_error !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: scan=%h sr=%b err=%b busy=%b want 00 0 0 0",
                     scan, scan_received, rx_error, busy);
        end
        wait_cycles(TIMEOUT + 50);
        checks++;
        if (err_cnt != e0 || rcv_q.size() != n0) begin
            errors++;
            $display("FAIL mid_reset_quiet: errs=%0d pulses=%0d want 0 0",
                     err_cnt - e0, rcv_q.size() - n0);
        end
        send_frame(make_frame(8'h12, 1'b0, 1'b1), HALF);
        checks++;
        if (rcv_q.size() != n0 + 1 || scan !== 8'h12) begin
            errors++;
            $display("FAIL after_reset: pulses=%0d scan=%h want 1 12", rcv_q.size() - n0, scan);
        end
        exp_scan = 8'h12;
    endtask

    task automatic test_random;
        int n0, e0, kind, half;
        logic [7:0] d;
        logic good;
        for (int t = 0; t < 24; t++) begin
            d    = 8'($urandom);
            kind = $urandom_range(0, 7);
            half = $urandom_range(14, 30);
            n0 = rcv_q.size(); e0 = err_cnt;
            good = (kind > 2);
            send_frame(make_frame(d, kind < 2, kind != 2), half);
            if (good) exp_scan = d;
            checks++;
            if (good && (rcv_q.size() != n0 + 1 || rcv_q[rcv_q.size()-1] !== d || err_cnt != e0)) begin
                errors++;
                $display("FAIL rand_%0d good: pulses=%0d got=%h errs=%0d want 1 %h 0",
                         t, rcv_q.size() - n0, rcv_q[rcv_q.size()-1], err_cnt - e0, d);
            end else if (!good && (rcv_q.size() != n0 || err_cnt != e0 + 1)) begin
                errors++;
                $display("FAIL rand_%0d bad: pulses=%0d errs=%0d want 0 1",
                         t, rcv_q.size() - n0, err_cnt - e0);
            end
            checks++;
            if (scan !== exp_scan || busy !== 1'b0) begin
                errors++;
                $display("FAIL rand_%0d scan: scan=%h busy=%b want %h 0", t, scan, busy, exp_scan);
            end
        end
    endtask

    task automatic test_invariants;
        int bad_w;
        bad_w = 0;
        foreach (width_q[i]) if (width_q[i] != 2) bad_w++;
        checks++;
        if (bad_w != 0) begin
            errors++;
            $display("FAIL pulse_widths: %0d pulses not 2 cycles wide", bad_w);
        end
        checks++;
        if (overlap != 0 || err_wide != 0 || unstable != 0) begin
            errors++;
            $display("FAIL invariants: overlap=%0d wide_err=%0d unstable_scan=%0d want 0 0 0",
                     overlap, err_wide, unstable);
        end
    endtask

    initial begin
        test_reset;
        test_single_frame;
        test_back_to_back;
        test_errors;
        test_glitch;
        test_timeout;
        test_reset_mid_frame;
        test_random;
        test_invariants;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
